// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the td4 OUT-port UART transmitter.
//
// Contents:
//   DATA_BITS   - data bits per frame
//   PARITY_BITS - 1 when TD4_TX_PARITY_EN is defined, else 0
//   FRAME_BITS  - start + data + parity + stop
//   tx_state_e  - transmitter FSM states (ST_PARITY only with TD4_TX_PARITY_EN)
//
// Configuration macro: TD4_TX_PARITY_EN (even parity bit between data and stop).
package td4_pkg;

  localparam int DATA_BITS = 8;

`ifdef TD4_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef TD4_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/td4_baud_gen.sv
// td4_baud_gen: bit-period timer for the td4 UART transmitter.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   clear_i  - restart the bit period (counter to zero on the next edge)
//   enable_i - count while high; counter holds when low
//   tick_o   - high during the last cycle of each DIV-cycle bit period
module td4_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick does not depend on clear_i so the FSM may derive clear from
  // its next state without forming a combinational loop.
  assign tick_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/td4_out_uart_tx.sv
// td4_out_uart_tx: sends every change of the td4 CPU OUT bus as a UART frame.
//
// Each change of OUT_PORT queues one byte in a small FIFO; the transmitter
// drains the FIFO as back-to-back 8N1 frames (8E1 with TD4_TX_PARITY_EN).
//
// Ports:
//   CLOCK    - single clock, rising edge
//   RESET    - asynchronous active-low reset
//   OUT_PORT - 8-bit CPU output bus, synchronous to CLOCK
//   TXD      - serial output, idle high (registered)
//   BUSY     - FIFO non-empty or frame in progress (registered)
//   OVERFLOW - sticky: a byte was dropped because the FIFO was full
//
// Configuration macro: TD4_TX_PARITY_EN (adds an even-parity bit).
module td4_out_uart_tx
  import td4_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] OUT_PORT,
  output logic       TXD,
  output logic       BUSY,
  output logic       OVERFLOW
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------
  // Change detection: prev_q holds the last sampled bus value; a push
  // is requested one cycle after a sampled value differed from it.
  // ---------------------------------------------------------------
  logic [7:0] prev_q;
  logic       push_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      prev_q <= 8'h00;
      push_q <= 1'b0;
    end else begin
      prev_q <= OUT_PORT;
      push_q <= (OUT_PORT != prev_q);
    end
  end

  // ---------------------------------------------------------------
  // Byte FIFO: wrapping pointers plus a separate occupancy count.
  // ---------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;
  logic             pop;
  logic [7:0]       head_data;
  logic             overflow_q;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_q && (!fifo_full || pop);
  assign head_data  = mem_q[rd_ptr_q];

  // prev_q still holds the changed value during the push cycle.
  always_ff @(posedge CLOCK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= prev_q;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_q && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------
  tx_state_e state_q;
  tx_state_e state_d;
  logic      tick;
  logic      baud_clear;
  logic      baud_enable;

  assign baud_enable = (state_q != ST_IDLE);
  assign baud_clear  = (state_d != state_q);

  td4_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk_i    (CLOCK),
    .rst_ni   (RESET),
    .clear_i  (baud_clear),
    .enable_i (baud_enable),
    .tick_o   (tick)
  );

  // ---------------------------------------------------------------
  // TX FSM: state register
  // ---------------------------------------------------------------
  logic [7:0] data_q;
  logic [2:0] bit_idx_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // TX FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_START;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick && (bit_idx_q == LAST_BIT)) begin
`ifdef TD4_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef TD4_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more bytes wait.
        if (tick) state_d = fifo_empty ? ST_IDLE : ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX FSM: outputs
  logic txd_d;
  logic busy_d;

  always_comb begin
    pop    = 1'b0;
    txd_d  = 1'b1;
    busy_d = !fifo_empty || (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:   pop = !fifo_empty;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = data_q[bit_idx_q];
`ifdef TD4_TX_PARITY_EN
      ST_PARITY: txd_d = ^data_q;
`endif
      ST_STOP: begin
        txd_d = 1'b1;
        pop   = tick && !fifo_empty;
      end
      default: txd_d = 1'b1;
    endcase
  end

  // Frame datapath: the byte is captured on pop and never touched until
  // the next pop, so later bus changes only queue.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      data_q    <= 8'h00;
      bit_idx_q <= 3'd0;
    end else begin
      if (pop) begin
        data_q    <= head_data;
        bit_idx_q <= 3'd0;
      end else if ((state_q == ST_DATA) && tick) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

  // Registered outputs; TXD follows the state one cycle later.
  logic txd_q;
  logic busy_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      txd_q  <= txd_d;
      busy_q <= busy_d;
    end
  end

  assign TXD      = txd_q;
  assign BUSY     = busy_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_td4_out_uart_tx.sv
module tb_td4_out_uart_tx;

  localparam int DIV = 434;  // 50 MHz / 115200, truncated
`ifdef TD4_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] out_port;
  logic       txd;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  td4_out_uart_tx dut (
    .CLOCK    (clk),
    .RESET    (rst_n),
    .OUT_PORT (out_port),
    .TXD      (txd),
    .BUSY     (busy),
    .OVERFLOW (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------
  // Scoreboard: expected bytes queued by stimulus, frames decoded
  // from TXD by the monitor below.
  // ------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start_ok;
    logic       stop_ok;
    int         start_cyc;
  } rx_t;

  logic [7:0] exp_q[$];
  rx_t        rx_q[$];

  bit  mon_active = 0;
  int  mon_cnt;
  int  mon_k;
  rx_t mon_frame;

  // Samples every bit in its middle; start_cyc is the edge at which TXD fell.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active          = 1;
        mon_cnt             = 0;
        mon_frame.start_cyc = cyc;
        mon_frame.data      = 8'h00;
        mon_frame.par       = 1'b0;
        mon_frame.start_ok  = 1'b1;
        mon_frame.stop_ok   = 1'b0;
      end
    end else begin
      mon_cnt++;
      if ((mon_cnt % DIV) == DIV / 2) begin
        mon_k = mon_cnt / DIV;
        if (mon_k == 0) begin
          mon_frame.start_ok = (txd === 1'b0);
        end else if (mon_k <= 8) begin
          mon_frame.data[mon_k-1] = txd;
        end else if (mon_k == FRAME - 1) begin
          mon_frame.stop_ok = (txd === 1'b1);
          rx_q.push_back(mon_frame);
          mon_active = 0;
        end else begin
          mon_frame.par = txd;
        end
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Bounded wait for n decoded frames; expiry is a counted failure.
  task automatic wait_rx(input int n, input int budget, input string tag);
    int waited = 0;
    while ((rx_q.size() < n) && (waited < budget)) begin
      @(negedge clk);
      waited++;
    end
    if (rx_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: frames=%0d required=%0d", tag, rx_q.size(), n);
    end
  endtask

  // ------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    out_port = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1)      begin failures++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL zero_no_push_busy: got %b want 0", busy); end
    checks++; if (rx_q.size() != 0)  begin failures++; $display("FAIL zero_no_push_frames: got %0d want 0", rx_q.size()); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int t0;
    rx_t r;
    logic [7:0] e;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    out_port = 8'hA5; exp_q.push_back(8'hA5); t0 = cyc + 1;
    wait_rx(1, FRAME * DIV + 50, "single");
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e) begin failures++; $display("FAIL single_data: got %h want %h", r.data, e); end
      checks++; if (!(r.start_ok && r.stop_ok)) begin failures++; $display("FAIL single_framing: start_ok=%b stop_ok=%b want 1 1", r.start_ok, r.stop_ok); end
      checks++; if (r.start_cyc != t0 + 3) begin failures++; $display("FAIL single_latency: start at %0d want %0d", r.start_cyc, t0 + 3); end
      wait_until(r.start_cyc + FRAME * DIV - 1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_end: got %b want 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_clear: got %b want 0", busy); end
      $display("test_single: byte %h started at cycle %0d", r.data, r.start_cyc);
    end
  endtask

  task automatic test_burst();
    rx_t r;
    logic [7:0] e;
    logic [7:0] v;
    int last_start;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      v = 8'(i);
      out_port = v;
      if (i <= 5) exp_q.push_back(v);
      @(negedge clk);
    end
    wait_rx(5, 6 * FRAME * DIV, "burst");
    last_start = 0;
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (r.data !== e) begin failures++; $display("FAIL burst_data%0d: got %h want %h", i, r.data, e); end
        checks++; if (!(r.start_ok && r.stop_ok)) begin failures++; $display("FAIL burst_framing%0d: start_ok=%b stop_ok=%b", i, r.start_ok, r.stop_ok); end
        if (i > 0) begin
          checks++; if (r.start_cyc - last_start != FRAME * DIV) begin failures++; $display("FAIL burst_gap%0d: got %0d want %0d", i, r.start_cyc - last_start, FRAME * DIV); end
        end
        last_start = r.start_cyc;
        $display("test_burst: byte %h at cycle %0d", r.data, r.start_cyc);
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow: got %b want 1", overflow); end
    repeat (FRAME * DIV + 100) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL burst_dropped: extra frames=%0d want 0", rx_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_hold();
    rx_t r;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    out_port = 8'h3C; exp_q.push_back(8'h3C);
    repeat (10000) @(negedge clk);
    checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL hold_count: got %0d frames want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      checks++; if (r.data !== exp_q[0]) begin failures++; $display("FAIL hold_data: got %h want %h", r.data, exp_q[0]); end
      $display("test_hold: byte %h, one frame", r.data);
    end
  endtask

`ifdef TD4_TX_PARITY_EN
  task automatic test_parity();
    rx_t r;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    out_port = 8'hA5;
    wait_rx(1, FRAME * DIV + 50, "parity_a5");
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      checks++; if (r.data !== 8'hA5) begin failures++; $display("FAIL parity_a5_data: got %h want a5", r.data); end
      checks++; if (r.par !== 1'b0)   begin failures++; $display("FAIL parity_a5_bit: got %b want 0", r.par); end
      wait_until(r.start_cyc + 4773);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL parity_len_busy: got %b want 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL parity_len_clear: got %b want 0", busy); end
    end
    @(negedge clk);
    out_port = 8'h07;
    wait_rx(1, FRAME * DIV + 50, "parity_07");
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      checks++; if (r.data !== 8'h07) begin failures++; $display("FAIL parity_07_data: got %h want 07", r.data); end
      checks++; if (r.par !== 1'b1)   begin failures++; $display("FAIL parity_07_bit: got %b want 1", r.par); end
      $display("test_parity: byte %h parity %b", r.data, r.par);
    end
    repeat (DIV) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_frame();
    int t0;
    rx_t r;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    out_port = 8'hA5; t0 = cyc + 1;
    repeat (5) @(negedge clk);
    out_port = 8'h02;
    // Data bit 3 of A5 is 0, so TXD is low when reset hits.
    wait_until(t0 + 3 + 4 * DIV + 200);
    #2;
    rst_n    = 1'b0;
    out_port = 8'h00;
    #1;
    checks++; if (txd !== 1'b1)      begin failures++; $display("FAIL midrst_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME * DIV + 100) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL midrst_resumed: got %0d frames want 0", rx_q.size()); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_idle_busy: got %b want 0", busy); end
    out_port = 8'h11; exp_q.push_back(8'h11); t0 = cyc + 1;
    wait_rx(1, FRAME * DIV + 50, "midrst_after");
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      checks++; if (r.data !== exp_q[0]) begin failures++; $display("FAIL midrst_after_data: got %h want %h", r.data, exp_q[0]); end
      checks++; if (r.start_cyc != t0 + 3) begin failures++; $display("FAIL midrst_after_latency: start %0d want %0d", r.start_cyc, t0 + 3); end
      $display("test_reset_mid_frame: byte %h after reset", r.data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_hold();
`ifdef TD4_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/td4_out_uart_tx.md
TD4_OUT_UART_TX -- requirements
Module: td4_out_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the CLOCK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate; divisor DIV = CLK_HZ/BAUD truncated, giving 434 at the defaults.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the byte queue depth, a power of two, at least 2.
REQ-004 SHALL have port CLOCK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port OUT_PORT, input, 8 bits: the td4 CPU OUT bus, synchronous to CLOCK.
REQ-007 SHALL have port TXD, output, 1 bit: UART serial output, idle high.
REQ-008 SHALL have port BUSY, output, 1 bit: high while the FIFO is non-empty or a frame is in progress.
REQ-009 SHALL have port OVERFLOW, output, 1 bit: sticky flag meaning at least one byte was dropped.

Function
REQ-010 SHALL register OUT_PORT into prev every cycle; a push request occurs in the cycle after the sampled value differs from prev.
REQ-011 SHALL load prev with 8'h00 at reset, so an OUT_PORT of 8'h00 after reset produces no push.
REQ-012 SHALL drop a push that arrives while the FIFO is full and no pop happens in the same cycle, and set OVERFLOW to 1 until reset.
REQ-013 SHALL accept both operations when a push and a pop occur in the same cycle, including when the FIFO is full; the count stays unchanged.
REQ-014 SHALL use pointers that wrap modulo FIFO_DEPTH and a separate count register for full and empty detection.
REQ-015 SHALL implement the TX FSM with states IDLE, START, DATA, PARITY and STOP; the PARITY state exists only under REQ-026.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head into a shift register and enter START in the same cycle.
REQ-017 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly DIV cycles, timed by a bit counter cleared on every state entry.
REQ-018 SHALL drive TXD as follows: 0 in START; data bits LSB first in DATA, using a 3-bit index; 1 in STOP and IDLE.
REQ-019 SHALL, at the end of STOP, pop and go directly to START if the FIFO is non-empty, otherwise go to IDLE; there is no idle gap between frames.
REQ-020 SHALL make TXD fall exactly 3 cycles after the clock edge that first samples a changed OUT_PORT, when the FIFO is empty and the FSM is in IDLE.
REQ-021 SHALL drive TXD and BUSY from registers, so the outputs are glitch-free.
REQ-022 SHALL never modify a frame in progress when OUT_PORT changes; new values only queue.

Reset
REQ-023 SHALL, while RESET is low and regardless of the clock, force TXD=1, BUSY=0, OVERFLOW=0, FSM=IDLE, the FIFO empty and prev=8'h00.
REQ-024 SHALL abort any frame in progress on reset, discard any partial transmission, and never resume it.
REQ-025 SHALL resume normal operation on the first rising CLOCK edge after RESET deasserts.

Configuration
REQ-026 SHALL, with TD4_TX_PARITY_EN defined, insert an even-parity bit (the XOR of the 8 data bits) between DATA and STOP, making a frame 11*DIV cycles.
REQ-027 SHALL, without TD4_TX_PARITY_EN, send 8N1 frames of 10*DIV cycles and contain no parity logic or PARITY state.

Structure
REQ-028 SHALL take the FSM state enumeration and the frame bit-count constants from the shared package td4_pkg.
REQ-029 SHALL place the bit-timing counter in one sub-module, td4_baud_gen, with inputs clear and enable and a tick output that pulses every DIV cycles.

Verification
REQ-030 SHALL cover this reset scenario: hold RESET low mid-run -> TXD=1, BUSY=0 and OVERFLOW=0 immediately, without waiting for a clock edge.
REQ-031 SHALL cover this single-byte scenario: change OUT_PORT from 00 to A5 -> TXD low 3 cycles later, then bits 1,0,1,0,0,1,0,1 at 434 cycles each, then stop high, with BUSY low 4340 cycles after the start bit.
REQ-032 SHALL cover this burst scenario: OUT_PORT steps 01,02,03,04,05,06 on consecutive cycles -> 01 through 05 are sent back-to-back with no gap, 06 is dropped, and OVERFLOW=1.
REQ-033 SHALL cover this hold scenario: OUT_PORT held at 3C for 10000 cycles after its first change -> exactly one frame is sent.
REQ-034 SHALL cover this parity scenario: with TD4_TX_PARITY_EN, send A5 -> parity bit 0 and a frame of 4774 cycles; send 07 -> parity bit 1.
REQ-035 SHALL cover this reset-mid-frame scenario: pulse RESET low during bit 4 of A5 with 02 queued -> TXD high, 02 is never sent, and a fresh change to 11 afterwards is sent normally.
